merge: RTL and testbench

Inverse of the SPLIT stage in the ALU1 polynomial datapath. Takes the even-index fragment and odd-index fragment of a GF(2^16) polynomial with 9 coefficients, and re-interleaves them into one packed 144-bit polynomial. It works one coefficient per cycle behind a start/done handshake. It feeds the square-root and recombination sequence, where f(x) = f0(x^2) + x·f1(x^2) must be rebuilt from its halves.

---
 rtl/merge.sv | 109 ++++++++++
 tb/tb_merge.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/merge.sv
// merge: re-interleaves the even-index and odd-index fragments of a
// 9-coefficient GF(2^16) polynomial back into one packed polynomial.
// One coefficient is written per cycle behind a start/done handshake.
// This block only moves data. It performs no arithmetic.
module merge #(
  parameter int DAT_W  = 144,
  parameter int COEF_W = 16,
  parameter int N_COEF = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [0:DAT_W-1] first_fragment_in,
  input  logic [0:DAT_W-1] second_fragment_in,
  output logic             busy,
  output logic             merge_done,
  output logic [0:DAT_W-1] poly_out
);

  localparam int CNT_W = $clog2(N_COEF);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [0:DAT_W-1]   r_first;
  logic [0:DAT_W-1]   r_second;
  logic [0:DAT_W-1]   r_poly;
  logic               r_done;

  logic               w_load;
  logic               w_write;
  logic               w_last;
  logic [CNT_W-1:0]   w_src_slot;
  logic [COEF_W-1:0]  w_coef;

  // Output slot cnt takes fragment slot cnt/2.
  // Even cnt reads the first fragment and odd cnt reads the second.
  assign w_src_slot = r_cnt >> 1;
  assign w_coef     = r_cnt[0] ? r_second[w_src_slot*COEF_W +: COEF_W]
                               : r_first[w_src_slot*COEF_W +: COEF_W];

  assign busy       = (r_state == S_RUN);
  assign merge_done = r_done;
  assign poly_out   = r_poly;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and datapath strobes: accept start only in IDLE, write one slot per RUN cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_write     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_write = 1'b1;
        if (r_cnt == CNT_W'(N_COEF - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture fragments at start, then fill poly_out one slot per cycle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the wide holding registers are cleared on reset as well.
    // An aborted merge then leaves no stale fragment data behind.
    if (rst) begin
      r_first  <= '0;
      r_second <= '0;
      r_poly   <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_first  <= first_fragment_in;
        r_second <= second_fragment_in;
        r_poly   <= '0;
        r_cnt    <= '0;
      end else if (w_write) begin
        r_poly[r_cnt*COEF_W +: COEF_W] <= w_coef;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_merge.sv
// tb_merge: directed bench for merge.
// A slot-level reference model predicts busy, merge_done and poly_out on every
// cycle. Literal expected polynomials pin the model to hand-computed values.
module tb_merge;

  localparam int DAT_W  = 144;
  localparam int COEF_W = 16;
  localparam int N_COEF = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [0:DAT_W-1] first_fragment_in;
  logic [0:DAT_W-1] second_fragment_in;
  logic             busy;
  logic             merge_done;
  logic [0:DAT_W-1] poly_out;

  merge #(.DAT_W(DAT_W), .COEF_W(COEF_W), .N_COEF(N_COEF)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .first_fragment_in  (first_fragment_in),
    .second_fragment_in (second_fragment_in),
    .busy               (busy),
    .merge_done         (merge_done),
    .poly_out           (poly_out)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_count  = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (merge_done === 1'b1) done_count <= done_count + 1;

  task automatic check(input string name, input logic [DAT_W-1:0] act, input logic [DAT_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Polynomial slot k: even k comes from first slot k/2, odd k from second slot k/2.
  function automatic logic [0:DAT_W-1] interleave(input logic [0:DAT_W-1] f, input logic [0:DAT_W-1] s);
    logic [0:DAT_W-1] r;
    r = '0;
    for (int k = 0; k < N_COEF; k++)
      r[k*COEF_W +: COEF_W] = (k % 2 == 0) ? f[(k/2)*COEF_W +: COEF_W] : s[(k/2)*COEF_W +: COEF_W];
    return r;
  endfunction

  // Only the first n slots are visible yet. The remaining slots read as zero.
  function automatic logic [0:DAT_W-1] visible(input logic [0:DAT_W-1] p, input int n);
    logic [0:DAT_W-1] r;
    r = p;
    for (int k = 0; k < N_COEF; k++)
      if (k >= n) r[k*COEF_W +: COEF_W] = '0;
    return r;
  endfunction

  bit               m_active = 1'b0;
  bit               m_done   = 1'b0;
  int               m_k      = 0;     // edges since the accepted start = slots written
  logic [0:DAT_W-1] m_res    = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_k      = 0;
      m_res    = '0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_k++;
        if (m_k == N_COEF) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end else if (start) begin
        m_res    = interleave(first_fragment_in, second_fragment_in);
        m_k      = 0;
        m_active = 1'b1;
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    check("busy", DAT_W'(busy), DAT_W'(m_active));
    check("merge_done", DAT_W'(merge_done), DAT_W'(m_done));
    check("poly_out", poly_out, visible(m_res, m_k));
  end

  // ---------------- directed vectors ----------------
  localparam logic [0:DAT_W-1] REF_F   = 144'h2F78_CE98_206A_9CFE_4746_0000_0000_0000_0000;
  localparam logic [0:DAT_W-1] REF_S   = 144'h093A_7914_035C_A1C4_0000_0000_0000_0000_0000;
  localparam logic [0:DAT_W-1] REF_P   = 144'h2F78_093A_CE98_7914_206A_035C_9CFE_A1C4_4746;
  localparam logic [0:DAT_W-1] DC_F    = 144'h2F78_CE98_206A_9CFE_4746_FFFF_FFFF_FFFF_FFFF;
  localparam logic [0:DAT_W-1] DC_S    = 144'h093A_7914_035C_A1C4_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [0:DAT_W-1] B2B_F   = 144'h0001_0001_0001_0001_0001_0000_0000_0000_0000;
  localparam logic [0:DAT_W-1] B2B_S   = 144'h0002_0002_0002_0002_0000_0000_0000_0000_0000;
  localparam logic [0:DAT_W-1] B2B_P   = 144'h0001_0002_0001_0002_0001_0002_0001_0002_0001;

  int c0;

  // Wait at falling edges for merge_done, bounded by a cycle budget.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (merge_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (merge_done !== 1'b1) check({name, "_timeout"}, 144'd0, 144'd1);
  endtask

  // Drive start=1 for one cycle. c0 records the cycle count after the start edge E0.
  task automatic issue(input logic [0:DAT_W-1] f, input logic [0:DAT_W-1] s);
    first_fragment_in  = f;
    second_fragment_in = s;
    start              = 1'b1;
    @(posedge clk);
    #1 c0 = cyc;
    start = 1'b0;
  endtask

  task automatic do_merge(input string name, input logic [0:DAT_W-1] f,
                          input logic [0:DAT_W-1] s, input logic [0:DAT_W-1] exp);
    @(negedge clk);
    issue(f, s);
    wait_done(name);
    check({name, "_latency"}, DAT_W'(cyc - c0), DAT_W'(N_COEF));
    check({name, "_poly"}, poly_out, exp);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    start = 1'b0;
    first_fragment_in  = '0;
    second_fragment_in = '0;

    // Reset held for 5 cycles; start pulsed while in reset must be ignored.
    repeat (2) @(negedge clk);
    first_fragment_in  = REF_F;
    second_fragment_in = REF_S;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", DAT_W'(busy), 144'd0);
    check("rst_done", DAT_W'(merge_done), 144'd0);
    check("rst_poly", poly_out, 144'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_busy", DAT_W'(busy), 144'd0);

    // Reference vector.
    do_merge("ref", REF_F, REF_S, REF_P);
    repeat (3) @(negedge clk);
    check("idle_hold_poly", poly_out, REF_P);

    // Don't-care slots filled with FFFF.
    do_merge("dontcare", DC_F, DC_S, REF_P);

    // Late input change at E3 and an ignored start at E5.
    @(negedge clk);
    d0 = done_count;
    issue(REF_F, REF_S);
    repeat (2) @(posedge clk);             // E1, E2
    @(posedge clk);                        // E3
    #1;
    first_fragment_in  = '1;
    second_fragment_in = '1;
    @(posedge clk);                        // E4
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);                        // E5 samples start while busy
    #1 start = 1'b0;
    wait_done("late");
    check("late_latency", DAT_W'(cyc - c0), DAT_W'(N_COEF));
    check("late_poly", poly_out, REF_P);
    repeat (12) @(negedge clk);
    check("late_single_done", DAT_W'(done_count - d0), 144'd1);

    // Back-to-back: a new start on the merge_done cycle.
    @(negedge clk);
    issue(REF_F, REF_S);
    wait_done("b2b_first");
    check("b2b_first_poly", poly_out, REF_P);
    issue(B2B_F, B2B_S);
    check("b2b_cleared", poly_out, 144'd0);
    wait_done("b2b_second");
    check("b2b_latency", DAT_W'(cyc - c0), DAT_W'(N_COEF));
    check("b2b_poly", poly_out, B2B_P);

    // Reset mid-merge, asserted between E4 and E5.
    @(negedge clk);
    issue(REF_F, REF_S);
    repeat (4) @(posedge clk);             // E1..E4
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", DAT_W'(busy), 144'd0);
    check("midrst_done", DAT_W'(merge_done), 144'd0);
    check("midrst_poly", poly_out, 144'd0);
    d0 = done_count;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_no_done", DAT_W'(done_count - d0), 144'd0);
    do_merge("after_rst", REF_F, REF_S, REF_P);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
